// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin arbiter sharing one block-RAM port among NREQ requesters
// Optional feature macro: BRAM_ARB_LOCK_EN (requester lock / exclusive ownership)
module bram_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 12,
    parameter int DW   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    input  logic [NREQ-1:0]    req_lock,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_din,
    input  logic [DW-1:0]      mem_dout
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef BRAM_ARB_LOCK_EN
    localparam logic LOCK_EN = 1'b1;
`else
    localparam logic LOCK_EN = 1'b0;
`endif

    typedef enum logic {ARB, LOCKED} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   ptr, ptr_next;
    logic [PW-1:0]   owner, owner_next;
    logic [PW-1:0]   gidx;
    logic [PW:0]     sum;
    logic            found;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] rsp_valid_q;
    logic            accept;
    logic            glock;

    // Grant selection: rotate from ptr in ARB, owner only in LOCKED; nothing while in reset
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        sum   = '0;
        if (!reset) begin
            if (state == LOCKED) begin
                grant[owner] = req_valid[owner];
                gidx         = owner;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    sum = {1'b0, ptr} + (PW+1)'(k);
                    if (sum >= (PW+1)'(NREQ)) begin
                        sum = sum - (PW+1)'(NREQ);
                    end
                    if (!found && req_valid[sum[PW-1:0]]) begin
                        grant[sum[PW-1:0]] = 1'b1;
                        gidx               = sum[PW-1:0];
                        found              = 1'b1;
                    end
                end
            end
        end
    end

    // RAM port drive: OR-mux of the granted requester, all-zero when idle
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        glock    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                mem_we   = req_we[i];
                mem_addr = req_addr[i*AW +: AW];
                mem_din  = req_wdata[i*DW +: DW];
                glock    = req_lock[i];
            end
        end
    end

    assign accept    = |grant;
    assign mem_en    = accept;
    assign req_ready = grant;

    // Next pointer / lock state; ptr only advances on an accepted transfer
    always_comb begin
        state_next = state;
        owner_next = owner;
        ptr_next   = ptr;
        if (accept) begin
            ptr_next = (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
            case (state)
                ARB: begin
                    if (LOCK_EN && glock) begin
                        state_next = LOCKED;
                        owner_next = gidx;
                    end
                end
                LOCKED: begin
                    if (!glock) begin
                        state_next = ARB;
                    end
                end
                default: state_next = ARB;
            endcase
        end
    end

    // State register and read-response strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ARB;
            ptr         <= '0;
            owner       <= '0;
            rsp_valid_q <= '0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            owner       <= owner_next;
            rsp_valid_q <= (accept && !mem_we) ? grant : '0;
        end
    end

    // A response due during a reset cycle is dropped rather than delivered
    assign rsp_valid = rsp_valid_q & {NREQ{~reset}};
    assign rsp_rdata = mem_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - directed scoreboard bench for bram_port_arbiter
module tb_bram_port_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 12;
    localparam int DW   = 8;

    logic               clock;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               mem_en;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_din;
    logic [DW-1:0]      mem_dout;

    logic [DW-1:0] ram [0:4095];

    typedef struct packed {
        logic [NREQ-1:0] v;
        logic [DW-1:0]   d;
    } exp_t;

    exp_t sb[$];
    int   tests_run;
    int   tests_failed;

    bram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_lock  (req_lock),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Block RAM model: registered read, one-cycle latency
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_din;
            mem_dout <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_lock  = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
        req_valid[i]         = v;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req_lock[i]          = l;
    endtask

    // One cycle: inputs already driven after a falling edge; check, queue response, advance
    task automatic tick(input logic [NREQ-1:0] eg, input logic [DW-1:0] ed, input string tag);
        exp_t            e;
        logic [AW-1:0]   ea;
        logic [DW-1:0]   edin;
        logic            ewe;
        ea   = '0;
        edin = '0;
        ewe  = 1'b0;
        #1;
        for (int j = 0; j < NREQ; j++) begin
            if (eg[j]) begin
                ea   = req_addr[j*AW +: AW];
                edin = req_wdata[j*DW +: DW];
                ewe  = req_we[j];
            end
        end
        check($sformatf("%s.grant", tag), 32'(req_ready), 32'(eg));
        check($sformatf("%s.mem_en", tag), 32'(mem_en), 32'(eg != '0));
        check($sformatf("%s.mem_we", tag), 32'(mem_we), 32'(ewe));
        check($sformatf("%s.mem_addr", tag), 32'(mem_addr), 32'(ea));
        check($sformatf("%s.mem_din", tag), 32'(mem_din), 32'(edin));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (reset) e.v = '0;
            check($sformatf("%s.rsp_valid", tag), 32'(rsp_valid), 32'(e.v));
            if (e.v != '0) check($sformatf("%s.rsp_rdata", tag), 32'(rsp_rdata), 32'(e.d));
        end else begin
            check($sformatf("%s.rsp_valid_idle", tag), 32'(rsp_valid), 32'(0));
        end
        e.v = (eg != '0 && !ewe) ? eg : '0;
        e.d = ed;
        sb.push_back(e);
        @(negedge clock);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        clear_all();
        @(negedge clock);

        // Reset holds off grants even with everyone requesting
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 12'(16 + i), 8'h00, 1'b0);
        tick(4'b0000, 8'h00, "reset0");
        tick(4'b0000, 8'h00, "reset1");
        reset = 1'b0;
        clear_all();

        // Preload through requester 0
        for (int i = 0; i < NREQ; i++) begin
            set_req(0, 1'b1, 1'b1, 12'(16 + i), 8'(160 + i), 1'b0);
            tick(4'b0001, 8'h00, "preload");
        end
        set_req(0, 1'b1, 1'b1, 12'h123, 8'h5A, 1'b0);
        tick(4'b0001, 8'h00, "preload_123");
        clear_all();
        reset = 1'b1;
        tick(4'b0000, 8'h00, "reset2");
        reset = 1'b0;

        // Round-robin with all requesters reading
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 12'(16 + i), 8'h00, 1'b0);
        for (int c = 0; c < 8; c++) tick(4'(1 << (c % 4)), 8'(160 + c % 4), "rr");
        clear_all();
        tick(4'b0000, 8'h00, "idle_rr");

        // Single read from requester 2
        set_req(2, 1'b1, 1'b0, 12'h123, 8'h00, 1'b0);
        tick(4'b0100, 8'h5A, "rd2");
        clear_all();
        tick(4'b0000, 8'h00, "idle_rd2");

        // Write then read same address, top of address space
        set_req(1, 1'b1, 1'b1, 12'hFFF, 8'hC3, 1'b0);
        tick(4'b0010, 8'h00, "wr1");
        set_req(1, 1'b1, 1'b0, 12'hFFF, 8'h00, 1'b0);
        tick(4'b0010, 8'hC3, "rd1");
        clear_all();
        tick(4'b0000, 8'h00, "idle_wr");

        // Sparse requesters 3 and 1 with ptr at 2
        set_req(3, 1'b1, 1'b0, 12'h013, 8'h00, 1'b0);
        set_req(1, 1'b1, 1'b0, 12'h011, 8'h00, 1'b0);
        tick(4'b1000, 8'hA3, "sparse0");
        tick(4'b0010, 8'hA1, "sparse1");
        tick(4'b1000, 8'hA3, "sparse2");
        clear_all();
        tick(4'b0000, 8'h00, "idle_sparse");

        // Lock sequence from requester 0 while 1..3 contend
        for (int i = 1; i < NREQ; i++) set_req(i, 1'b1, 1'b1, 12'(512 + i), 8'(i), 1'b0);
        set_req(0, 1'b1, 1'b1, 12'h200, 8'h77, 1'b1);
        tick(4'b0001, 8'h00, "lock0");
        set_req(0, 1'b1, 1'b1, 12'h200, 8'h78, 1'b1);
`ifdef BRAM_ARB_LOCK_EN
        tick(4'b0001, 8'h00, "lock1");
`else
        tick(4'b0010, 8'h00, "lock1");
`endif
        set_req(0, 1'b1, 1'b1, 12'h200, 8'h79, 1'b0);
`ifdef BRAM_ARB_LOCK_EN
        tick(4'b0001, 8'h00, "lock2");
`else
        tick(4'b0100, 8'h00, "lock2");
`endif
        set_req(0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
`ifdef BRAM_ARB_LOCK_EN
        tick(4'b0010, 8'h00, "lock3");
`else
        tick(4'b1000, 8'h00, "lock3");
`endif
        clear_all();
        tick(4'b0000, 8'h00, "idle_lock");

        // Reset right after an accepted read drops the response
        set_req(1, 1'b1, 1'b0, 12'h011, 8'h00, 1'b0);
        tick(4'b0010, 8'hA1, "rst_mid_rd");
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 12'(16 + i), 8'h00, 1'b0);
        tick(4'b0000, 8'h00, "rst_mid0");
        tick(4'b0000, 8'h00, "rst_mid1");
        reset = 1'b0;
        tick(4'b0001, 8'hA0, "post_rst");
        clear_all();
        tick(4'b0000, 8'h00, "drain");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter that shares one port of the 8-bit x 4096-entry dual-port block RAM between NREQ requesters. Each requester gets a valid/ready request channel and a read-response strobe. The arbiter drives the RAM port's enable, write-enable, address and data lines. It sits between the CPU-side clients (fetch, load/store, DMA, debug) and the RAM shell; the shell's other port stays dedicated to a single owner.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 12, RAM address width
- DW, 8, RAM data width

Ports:
- clock  input  1  single clock; every register updates on its rising edge
- reset  input  1  synchronous, active-high
- req_valid  input  NREQ  request pending, one bit per requester
- req_ready  output  NREQ  one-hot grant; a transfer occurs when valid & ready
- req_we  input  NREQ  1 = write, 0 = read
- req_addr  input  NREQ*AW  requester i's address in bits [i*AW +: AW]
- req_wdata  input  NREQ*DW  requester i's write data in bits [i*DW +: DW]
- req_lock  input  NREQ  lock request (honoured only with BRAM_ARB_LOCK_EN)
- rsp_valid  output  NREQ  read data valid for requester i
- rsp_rdata  output  DW  shared read data, qualified by rsp_valid
- mem_en  output  1  RAM port enable
- mem_we  output  1  RAM port write enable
- mem_addr  output  AW  RAM port address
- mem_din  output  DW  RAM port write data
- mem_dout  input  DW  RAM port read data (registered inside the RAM, 1-cycle latency)

## Operation
Registered state:
- ptr: round-robin pointer, 0..NREQ-1
- state: ARB or LOCKED
- owner: requester index held in LOCKED
- rsp_valid register

Grant (combinational):
- In ARB, grant goes to the first requester with req_valid=1, searching ptr, ptr+1, ..., wrapping modulo NREQ.
- In LOCKED, grant goes only to owner, and only when req_valid[owner]=1. All other requesters see req_ready=0.
- req_ready is the grant vector. It is never multi-hot, and is all-zero when no requester is eligible.

RAM drive (combinational):
- mem_en = |grant.
- mem_we, mem_addr, mem_din are muxed from the granted requester.
- When nothing is granted: mem_en=0, mem_we=0, mem_addr=0, mem_din=0.

On an accepted transfer from requester i:
- ptr <= (i+1) mod NREQ. ptr does not move on idle cycles.
- If it is a read, rsp_valid[i] is set in the next cycle; all other rsp_valid bits are 0.
- A write produces no response.

Response data:
- rsp_rdata = mem_dout, passed through directly.
- rsp_rdata is meaningful only when some rsp_valid bit is 1.

Collision ordering:
- Port-level collisions with the RAM's other port are not checked; software owns them.
- A read and a write to the same address from this port in consecutive cycles return the new data, because the write is committed before the read edge.

Reset (reset=1 at a rising edge):
- ptr=0, state=ARB, owner=0, rsp_valid=0.
- A read accepted in the cycle before reset loses its response.
- While reset is high, req_ready and mem_en are forced to 0.

## Timing
- Throughput: one transfer per cycle, back-to-back across different requesters.
- Read accepted at edge N: rsp_valid[i]=1 during cycle N+1, carrying data from address A.
- Write accepted at edge N: the RAM holds the new data after edge N.
- No combinational path from mem_dout to req_ready.
- Fairness: with all NREQ requesters continuously valid and no lock, each is granted exactly once in every NREQ consecutive cycles.

## Configuration
BRAM_ARB_LOCK_EN is the one compile-time option.

When BRAM_ARB_LOCK_EN is defined:
- An accepted transfer with req_lock[i]=1 while in ARB moves state to LOCKED and sets owner=i.
- In LOCKED, an accepted owner transfer with req_lock=0 returns state to ARB, with ptr=(owner+1) mod NREQ.
- The owner dropping req_valid does not release the lock.
- reset always returns state to ARB.

When BRAM_ARB_LOCK_EN is not defined:
- req_lock is ignored and state remains ARB permanently.

## Test plan
- Single read: preload RAM[0x123]=0x5A. Requester 2 reads 0x123 -> req_ready=4'b0100 that cycle, then rsp_valid=4'b0100 and rsp_rdata=0x5A one cycle later.
- Round-robin: all 4 requesters hold valid for 8 cycles starting from reset -> grant sequence 0,1,2,3,0,1,2,3, and mem_en=1 every cycle.
- Write then read: requester 1 writes 0xC3 to 0xFFF, then reads 0xFFF in the next cycle -> rsp_rdata=0xC3, rsp_valid=4'b0010.
- Sparse requesters: only requesters 3 and 1 are valid, with ptr=2 -> grant 3, then 1, then 3; no grant to 0 or 2, and ptr wraps correctly.
- Lock (macro defined): requester 0 issues 3 transfers with lock=1,1,0 while requesters 1 to 3 are valid -> three consecutive grants to 0, then grant to 1. Without the macro, the grants are 0,1,2,3.
- Reset mid-read: a read is accepted, then reset is asserted the next cycle -> rsp_valid=0, req_ready=0, mem_en=0. After reset is released, the first grant goes to requester 0.
